dot_product_seq: RTL
====================

# dot_product_seq

Sequential scheduler for the vector dot product. It accepts element pairs over a valid/ready stream, drives a single multiply-accumulate stage once per accepted pair, and returns one result per LEN-element vector on a valid/ready output. It sits between a vector source (memory reader or host FIFO) and the result consumer, and replaces the fully parallel multiplier array with one shared MAC. This trades throughput for area.

## Interface
- W, 8, element width in bits (unsigned operands)
- LEN, 8, elements per vector, LEN >= 1
- ACC_W, 2*W + $clog2(LEN), accumulator and result width (derived, not overridden)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- soft_clr  in  1  synchronous abort: drop partial sum and pending result
- in_valid  in  1  element pair valid
- in_ready  out  1  block accepts a pair this cycle
- in_a  in  W  element of vector a
- in_b  in  W  element of vector b
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result this cycle
- out_result  out  ACC_W  dot product of the last complete vector
- busy  out  1  high when the state is ACCUM or DONE

## Operation
- Reset: clk and one reset only; rst_n is asynchronous and active-low. While rst_n = 0: state = IDLE, count = 0, acc = 0, out_valid = 0, out_result = 0, busy = 0, in_ready = 0. The first cycle after release gives in_ready = 1.
- Accept means in_valid && in_ready. On each accept the product is in_a*in_b (unsigned, 2W bits), zero-extended to ACC_W.
- The first accept of a vector loads acc = product. Each later accept does acc = acc + product.
- ACC_W cannot overflow for LEN products of W-bit maxima. No saturation and no flag.
- States:
  - IDLE: count = 0, in_ready = 1. On accept, go to ACCUM with count = 1. If LEN = 1, go straight to DONE.
  - ACCUM: in_ready = 1. Each accept increments count. The accept at count = LEN-1 goes to DONE.
  - DONE: in_ready = 0 and out_valid = 1. out_result = acc and is held stable until out_valid && out_ready. That handshake clears out_valid, count and acc, and returns the state to IDLE.
- in_valid bubbles are allowed anywhere in a vector. State and acc hold during bubbles. There is no timeout.
- soft_clr has the highest priority. In any state it forces IDLE, count = 0, acc = 0 and out_valid = 0 on the next edge.
  - An accept in the same cycle as soft_clr is discarded.
  - An out_ready in the same cycle as soft_clr is a no-op: the consumer must not count that result.
- out_valid, once high, never drops without out_ready, except on soft_clr or rst_n.
- in_ready and busy are decoded from state only and do not depend on in_valid or out_ready, so there is no combinational path from input to output.

## Timing
- Accept rate in IDLE/ACCUM: one pair per cycle.
- Latency: out_valid rises on the clock edge after the LEN-th accept, so out_result is visible in the following cycle.
- Minimum vector period: LEN + 1 cycles (LEN accepts plus one DONE cycle with out_ready = 1). in_ready returns the cycle after the output handshake.
- Asserting rst_n mid-vector clears all outputs immediately, with no clock needed. The partial vector is lost.

## Structure
- Package dp_pkg holds the state enum (IDLE, ACCUM, DONE) and the localparam function for ACC_W and the count width $clog2(LEN+1).
- Sub-module dp_mac is the registered accumulator: inputs en, load, a, b; output acc. dp_mac applies load/accumulate priority and owns the only multiplier.
- The top level holds the FSM, count and handshake decode.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles -> out_valid = 0, out_result = 0, busy = 0, in_ready = 0. The cycle after release gives in_ready = 1 and busy = 0.
- Nominal (W = 8, LEN = 8): a = 1..8 and b = 8..1 back-to-back with out_ready = 1 -> out_valid is high exactly one cycle after the 8th accept, out_result = 120, then in_ready = 1 the next cycle.
- Width corner: all a = b = 255 -> out_result = 520200 (19-bit ACC_W, no wrap). Then a = b = 0 -> 0, with no residue from the previous vector.
- Backpressure and bubbles:
  - Random in_valid gaps on the 1..8 / 8..1 vector -> out_result = 120.
  - Hold out_ready = 0 for 5 cycles -> out_result stays stable, in_ready = 0, and asserted in_valid is ignored.
  - Release out_ready, then send an all-ones vector -> out_result = 8.
- soft_clr:
  - Pulse after 4 accepts, with in_valid high in the same cycle -> IDLE and busy = 0. A following 1..8 / 8..1 vector gives 120.
  - Pulse in DONE together with out_ready = 1 -> out_valid drops and no result is counted.
- Async reset mid-operation: drop rst_n between clock edges at element 5 -> busy and out_valid go to 0 immediately. After release, a full vector gives the correct result.

Source files
------------

// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - shared state encoding and width helpers for the sequential dot product
package dp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Wide enough that LEN full-scale products can never wrap.
  function automatic int acc_width(input int w, input int len);
    return 2 * w + $clog2(len);
  endfunction

  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/dp_mac.sv
// rtl/dp_mac.sv - registered multiply-accumulate stage, the only multiplier in the block
module dp_mac
  import dp_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [ACC_W-1:0] acc
);

  logic [2*W-1:0]   prod;
  logic [ACC_W-1:0] acc_q, acc_d;

  assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};

  // Clear beats load beats accumulate.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      if (load) begin
        acc_d = ACC_W'(prod);
      end else begin
        acc_d = acc_q + ACC_W'(prod);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/dot_product_seq.sv
// rtl/dot_product_seq.sv - streams LEN element pairs through one MAC and returns their dot product
module dot_product_seq
  import dp_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int LEN   = 8,
  localparam int ACC_W = acc_width(W, LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             soft_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_result,
  output logic             busy
);

  localparam int              CNT_W = cnt_width(LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;
  logic             mac_en, mac_load, mac_clr;

  // Gated by rst_n so the source sees no ready while reset is held.
  assign in_ready  = rst_n && (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mac_en   = 1'b0;
    mac_load = 1'b0;
    mac_clr  = 1'b0;
    if (soft_clr) begin
      state_d = IDLE;
      count_d = '0;
      mac_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            mac_en   = 1'b1;
            mac_load = 1'b1;
            count_d  = CNT_W'(1);
            state_d  = (LEN == 1) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            mac_en  = 1'b1;
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST) state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            count_d = '0;
            mac_clr = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  dp_mac #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .load  (mac_load),
    .a     (in_a),
    .b     (in_b),
    .acc   (out_result)
  );

endmodule
